// File: rtl/microseq_stack.sv
// microseq_stack: next-microaddress sequencer with a small return stack.
// Produces the registered microaddress (upc) for the microrom. Supported ops are
// next, jump, conditional branch, IR dispatch, call and return. The return stack
// lets addressing-mode routines nest. Overflow and underflow are reported by
// sticky flags.
module microseq_stack #(
  parameter int unsigned AW         = 9,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [2:0]                   op,
  input  logic [AW-1:0]                target,
  input  logic                         cond,
  input  logic [AW-1:0]                dispatch_addr,
  output logic [AW-1:0]                upc,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         halted,
  output logic                         ovf,
  output logic                         unf
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_ZERO = DW'(0);
  localparam logic [DW-1:0] DEPTH_ONE  = DW'(1);
  localparam logic [AW-1:0] RST_UPC    = AW'(RESET_ADDR);
  localparam logic [AW-1:0] UPC_ONE    = AW'(1);

  typedef enum logic [2:0] {
    OP_NEXT  = 3'd0,
    OP_JMP   = 3'd1,
    OP_JZ    = 3'd2,
    OP_JNZ   = 3'd3,
    OP_CALL  = 3'd4,
    OP_CALLD = 3'd5,
    OP_RET   = 3'd6,
    OP_HALT  = 3'd7
  } op_e;

  logic [AW-1:0] upc_r;
  logic [DW-1:0] depth_r;
  logic          halted_r;
  logic          ovf_r;
  logic          unf_r;
  logic [AW-1:0] stack_r [DEPTH];

  op_e           op_s;
  logic [AW-1:0] upc_inc_s;
  logic [DW-1:0] depth_dec_s;
  logic [IW-1:0] wr_idx_s;
  logic [IW-1:0] top_idx_s;
  logic [AW-1:0] upc_nxt_s;
  logic [DW-1:0] depth_nxt_s;
  logic          halted_nxt_s;
  logic          ovf_nxt_s;
  logic          unf_nxt_s;
  logic          push_s;

  assign op_s        = op_e'(op);
  assign upc_inc_s   = upc_r + UPC_ONE;
  assign depth_dec_s = depth_r - DEPTH_ONE;
  // The free slot is entry[depth]; the top of stack is entry[depth-1].
  assign wr_idx_s    = depth_r[IW-1:0];
  assign top_idx_s   = depth_dec_s[IW-1:0];

  // Next-state decode: default to hold, then apply the current op unless frozen.
  always_comb begin
    upc_nxt_s    = upc_r;
    depth_nxt_s  = depth_r;
    halted_nxt_s = halted_r;
    ovf_nxt_s    = ovf_r;
    unf_nxt_s    = unf_r;
    push_s       = 1'b0;
    if (stall || halted_r) begin
      upc_nxt_s = upc_r;
    end else begin
      case (op_s)
        OP_NEXT: upc_nxt_s = upc_inc_s;
        OP_JMP:  upc_nxt_s = dispatch_addr;
        OP_JZ:   upc_nxt_s = cond ? target : upc_inc_s;
        OP_JNZ:  upc_nxt_s = cond ? upc_inc_s : target;
        OP_CALL, OP_CALLD: begin
          // The jump is always taken; only the push is dropped when the stack is full.
          upc_nxt_s = (op_s == OP_CALL) ? target : dispatch_addr;
          if (depth_r == DEPTH_FULL) begin
            ovf_nxt_s = 1'b1;
          end else begin
            push_s      = 1'b1;
            depth_nxt_s = depth_r + DEPTH_ONE;
          end
        end
        OP_RET: begin
          if (depth_r == DEPTH_ZERO) begin
            upc_nxt_s = RST_UPC;
            unf_nxt_s = 1'b1;
          end else begin
            upc_nxt_s   = stack_r[top_idx_s];
            depth_nxt_s = depth_dec_s;
          end
        end
        OP_HALT: halted_nxt_s = 1'b1;
        default: upc_nxt_s = upc_r;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      upc_r    <= RST_UPC;
      depth_r  <= DEPTH_ZERO;
      halted_r <= 1'b0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      upc_r    <= upc_nxt_s;
      depth_r  <= depth_nxt_s;
      halted_r <= halted_nxt_s;
      ovf_r    <= ovf_nxt_s;
      unf_r    <= unf_nxt_s;
    end
  end

  // Return-stack storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      stack_r[wr_idx_s] <= upc_inc_s;
    end
  end

  assign upc    = upc_r;
  assign depth  = depth_r;
  assign halted = halted_r;
  assign ovf    = ovf_r;
  assign unf    = unf_r;

endmodule

// File: tb/tb_microseq_stack.sv
// Testbench for microseq_stack: directed scenarios plus random ops.
// A queue-based reference model supplies the expected state after every edge.
module tb_microseq_stack;

  localparam int AW    = 9;
  localparam int DEPTH = 4;
  localparam int RADDR = 0;
  localparam int MODV  = 1 << AW;
  localparam int DW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic [2:0]    op;
  logic [AW-1:0] target;
  logic          cond;
  logic [AW-1:0] dispatch_addr;
  logic [AW-1:0] upc;
  logic [DW-1:0] depth;
  logic          halted;
  logic          ovf;
  logic          unf;

  microseq_stack #(.AW(AW), .DEPTH(DEPTH), .RESET_ADDR(RADDR)) dut (
    .clk(clk), .reset(reset), .stall(stall), .op(op), .target(target),
    .cond(cond), .dispatch_addr(dispatch_addr), .upc(upc), .depth(depth),
    .halted(halted), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    upc;
    int    depth;
    bit    halted;
    bit    ovf;
    bit    unf;
    string name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int m_upc;
  int m_stack[$];
  bit m_halted, m_ovf, m_unf;

  task automatic cmp(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, and queue the expected result.
  task automatic step(input bit r, input bit st, input int o, input int tg,
                      input bit c, input int da, input string nm);
    exp_t e;
    @(negedge clk);
    reset = r; stall = st; op = 3'(o); target = AW'(tg); cond = c;
    dispatch_addr = AW'(da);
    if (r) begin
      m_upc = RADDR; m_stack.delete(); m_halted = 0; m_ovf = 0; m_unf = 0;
    end else if (!st && !m_halted) begin
      case (o)
        0: m_upc = (m_upc + 1) % MODV;
        1: m_upc = da;
        2: m_upc = c ? tg : (m_upc + 1) % MODV;
        3: m_upc = !c ? tg : (m_upc + 1) % MODV;
        4, 5: begin
          if (m_stack.size() < DEPTH) m_stack.push_back((m_upc + 1) % MODV);
          else m_ovf = 1;
          m_upc = (o == 4) ? tg : da;
        end
        6: begin
          if (m_stack.size() == 0) begin m_upc = RADDR; m_unf = 1; end
          else m_upc = m_stack.pop_back();
        end
        default: m_halted = 1;
      endcase
    end
    e.upc = m_upc; e.depth = m_stack.size(); e.halted = m_halted;
    e.ovf = m_ovf; e.unf = m_unf; e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: after each active edge, compare DUT outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp({e.name, ".upc"},    int'(upc),    e.upc);
        cmp({e.name, ".depth"},  int'(depth),  e.depth);
        cmp({e.name, ".halted"}, int'(halted), int'(e.halted));
        cmp({e.name, ".ovf"},    int'(ovf),    int'(e.ovf));
        cmp({e.name, ".unf"},    int'(unf),    int'(e.unf));
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; op = 3'd0; target = '0; cond = 1'b0; dispatch_addr = '0;

    // T1: reset then three NEXTs
    step(1, 0, 0, 0, 0, 0, "t1_reset");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, "t1_next");

    // T2: from upc 002, CALLD then RET
    step(1, 0, 0, 0, 0, 0, "t2_reset");
    step(0, 0, 0, 0, 0, 0, "t2_next");
    step(0, 0, 0, 0, 0, 0, "t2_next");
    step(0, 0, 5, 'h1aa, 0, 'h140, "t2_calld");
    step(0, 0, 6, 0, 0, 0, "t2_ret");

    // T3: five nested CALLs from 010, then five RETs
    step(0, 0, 1, 0, 0, 'h010, "t3_jmp");
    for (int i = 0; i < 5; i++) step(0, 0, 4, 'h100 + 16 * i, 0, 0, "t3_call");
    for (int i = 0; i < 5; i++) step(0, 0, 6, 0, 0, 0, "t3_ret");

    // T4: JZ / JNZ taken and not taken
    step(0, 0, 1, 0, 0, 'h008, "t4_jmp");
    step(0, 0, 2, 'h00e, 1, 0, "t4_jz_taken");
    step(0, 0, 1, 0, 0, 'h008, "t4_jmp");
    step(0, 0, 2, 'h00e, 0, 0, "t4_jz_fall");
    step(0, 0, 1, 0, 0, 'h008, "t4_jmp");
    step(0, 0, 3, 'h00e, 0, 0, "t4_jnz_taken");
    step(0, 0, 1, 0, 0, 'h008, "t4_jmp");
    step(0, 0, 3, 'h00e, 1, 0, "t4_jnz_fall");

    // T5: wrap at all-ones, stalled CALL
    step(0, 0, 1, 0, 0, 'h1ff, "t5_jmp");
    step(0, 0, 0, 0, 0, 0, "t5_wrap");
    step(0, 0, 4, 'h055, 0, 0, "t5_call");
    step(0, 1, 4, 'h077, 0, 0, "t5_stall_call");
    step(0, 1, 6, 0, 0, 0, "t5_stall_ret");

    // T6: HALT freezes everything until reset; reset beats stall
    step(0, 0, 7, 0, 0, 0, "t6_halt");
    for (int i = 0; i < 10; i++)
      step(0, 0, $urandom_range(0, 7), $urandom_range(0, MODV - 1), 1'($urandom),
           $urandom_range(0, MODV - 1), "t6_frozen");
    step(1, 1, 4, 'h033, 0, 0, "t6_reset_stall");

    // Random phase
    for (int i = 0; i < 800; i++) begin
      bit r, st;
      int o;
      r  = (m_halted && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 99) == 0);
      st = ($urandom_range(0, 7) == 0);
      o  = $urandom_range(0, 15);
      if (o > 7) o = (o < 11) ? 4 : (o < 14) ? 6 : 0; // bias toward stack activity
      step(r, st, o, $urandom_range(0, MODV - 1), 1'($urandom),
           $urandom_range(0, MODV - 1), "rnd");
    end

    // Let the monitor drain; a leftover entry means an unchecked cycle
    @(negedge clk);
    @(negedge clk);
    cmp("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
